// File: rtl/clk_tick_gen.sv
// Multi-channel programmable tick generator: each channel emits a one-cycle tick
// every d enabled cycles and a square wave that toggles on every tick.
module clk_tick_gen #(
  parameter  int NUM_CH      = 4,
  parameter  int CNT_W       = 27,
  parameter  int DEFAULT_DIV = 50_000_000,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              load,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [CNT_W-1:0]  div_in,
  output logic [CNT_W-1:0]  rd_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] div_all [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] div_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             tick_reg;
      logic             sq_reg;
      logic [CNT_W-1:0] last_cnt;
      logic             sel;

      // Divisors 0 and 1 both collapse to "tick every enabled cycle".
      assign last_cnt = (div_reg < CNT_W'(2)) ? '0 : div_reg - CNT_W'(1);
      assign sel      = load && (ch_sel == CH_W'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          div_reg  <= DIV_RST;
          cnt_reg  <= '0;
          tick_reg <= 1'b0;
          sq_reg   <= 1'b0;
        end else if (sync_clr) begin
          cnt_reg  <= '0;
          tick_reg <= 1'b0;
          sq_reg   <= 1'b0;
        end else if (sel) begin
          // A load restarts the period and suppresses any coincident terminal tick.
          div_reg  <= div_in;
          cnt_reg  <= '0;
          tick_reg <= 1'b0;
        end else if (!en[gi]) begin
          tick_reg <= 1'b0;
        end else if (cnt_reg == last_cnt) begin
          cnt_reg  <= '0;
          tick_reg <= 1'b1;
          sq_reg   <= ~sq_reg;
        end else begin
          cnt_reg  <= cnt_reg + CNT_W'(1);
          tick_reg <= 1'b0;
        end
      end

      assign div_all[gi] = div_reg;
      assign tick[gi]    = tick_reg;
      assign sq[gi]      = sq_reg;
    end
  endgenerate

  always_comb begin
    rd_div = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_W'(i)) rd_div = div_all[i];
    end
  end

endmodule
